// File: rtl/bypass_pkg.sv
// Shared constants for the operand-forwarding/hazard slice: default widths,
// forwarding tap indices and the nominal pipe latencies.
package bypass_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned NRD_DEF  = 2;
  localparam int unsigned NSRC_DEF = 8;
  localparam int unsigned LW_DEF   = 3;
  localparam int unsigned CNT_W    = 32;

  // Tap order: lower index is younger, so it wins on a multi-match
  localparam int unsigned SRC_EXE   = 0;
  localparam int unsigned SRC_MUL1  = 1;
  localparam int unsigned SRC_MUL2  = 2;
  localparam int unsigned SRC_MUL3  = 3;
  localparam int unsigned SRC_MUL4  = 4;
  localparam int unsigned SRC_MUL5  = 5;
  localparam int unsigned SRC_CACHE = 6;
  localparam int unsigned SRC_WB    = 7;

  localparam int unsigned LAT_ALU = 1;
  localparam int unsigned LAT_MUL = 6;
  localparam int unsigned LAT_LD  = 7;

endpackage

// File: rtl/bypass_scoreboard_if.sv
// Decode-side bundle of the bypass scoreboard: operand reads, issue request,
// forwarding taps and the forwarded/stall results.
interface bypass_scoreboard_if
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NRD  = NRD_DEF,
  parameter int unsigned NSRC = NSRC_DEF,
  parameter int unsigned LW   = LW_DEF
) ();

  logic [NRD*AW-1:0]    rd_addr_i;
  logic [NRD-1:0]       rd_en_i;
  logic                 iss_valid_i;
  logic                 iss_wr_en_i;
  logic [AW-1:0]        iss_addr_i;
  logic [LW-1:0]        iss_lat_i;
  logic                 flush_i;
  logic [NSRC*XLEN-1:0] src_data_i;
  logic [NSRC*AW-1:0]   src_addr_i;
  logic [NSRC-1:0]      src_wr_en_i;
  logic [NRD-1:0]       bypass_en_o;
  logic [NRD*XLEN-1:0]  bypass_data_o;
  logic                 stall_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  modport master (
    output rd_addr_i, rd_en_i, iss_valid_i, iss_wr_en_i, iss_addr_i, iss_lat_i,
           flush_i, src_data_i, src_addr_i, src_wr_en_i,
    input  bypass_en_o, bypass_data_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  rd_addr_i, rd_en_i, iss_valid_i, iss_wr_en_i, iss_addr_i, iss_lat_i,
           flush_i, src_data_i, src_addr_i, src_wr_en_i,
    output bypass_en_o, bypass_data_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/bypass_mux.sv
// Single read-port forwarding mux: picks the youngest (lowest index) tap whose
// destination matches the operand address. Register 0 never matches.
module bypass_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NSRC = 8
) (
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_wr_en,
  output logic                 hit,
  output logic [XLEN-1:0]      data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rd_en && (rd_addr != '0)) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (!hit && src_wr_en[s] && (src_addr[s*AW +: AW] == rd_addr)) begin
          hit  = 1'b1;
          data = src_data[s*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Per-register write scoreboard with latency countdown, operand forwarding
// from the pipe taps, RAW/WAW issue stall and a saturating stall counter.
module bypass_scoreboard
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NRD  = NRD_DEF,
  parameter int unsigned NSRC = NSRC_DEF,
  parameter int unsigned LW   = LW_DEF
) (
  input  logic clk_i,
  input  logic rsn_i,
  bypass_scoreboard_if.slave bus
);

  localparam int unsigned NREG = 1 << AW;

  logic [NREG-1:0]     pend_q, pend_d;
  logic [LW-1:0]       cnt_q [NREG];
  logic [LW-1:0]       cnt_d [NREG];
  logic [CNT_W-1:0]    stall_cnt_q;

  logic [AW-1:0]       rd_addr_a [NRD];
  logic [NRD-1:0]      hit;
  logic [NRD*XLEN-1:0] mux_data;
  logic [LW-1:0]       lat_eff_c;
  logic                raw_c;
  logic                waw_c;
  logic                stall_c;
  logic                issue_c;

  // One priority mux per operand port
  for (genvar p = 0; p < NRD; p++) begin : g_port
    assign rd_addr_a[p] = bus.rd_addr_i[p*AW +: AW];

    bypass_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .NSRC (NSRC)
    ) u_mux (
      .rd_en     (bus.rd_en_i[p]),
      .rd_addr   (rd_addr_a[p]),
      .src_data  (bus.src_data_i),
      .src_addr  (bus.src_addr_i),
      .src_wr_en (bus.src_wr_en_i),
      .hit       (hit[p]),
      .data      (mux_data[p*XLEN +: XLEN])
    );
  end

  // A zero latency still needs one cycle to reach writeback
  assign lat_eff_c = (bus.iss_lat_i == '0) ? LW'(1) : bus.iss_lat_i;

  always_comb begin
    raw_c = 1'b0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (bus.rd_en_i[p] && (rd_addr_a[p] != '0) && pend_q[rd_addr_a[p]] && !hit[p]) begin
        raw_c = 1'b1;
      end
    end
  end

  // An older write landing after the new one would break per-register order
  assign waw_c = bus.iss_valid_i && bus.iss_wr_en_i && pend_q[bus.iss_addr_i]
                 && (cnt_q[bus.iss_addr_i] > lat_eff_c);

  assign stall_c = rsn_i && bus.iss_valid_i && (raw_c || waw_c) && !bus.flush_i;

  assign issue_c = bus.iss_valid_i && bus.iss_wr_en_i && !stall_c && !bus.flush_i
                   && (bus.iss_addr_i != '0);

  assign bus.bypass_en_o   = rsn_i ? hit : '0;
  assign bus.bypass_data_o = rsn_i ? mux_data : '0;
  assign bus.stall_o       = stall_c;
  assign bus.stall_cnt_o   = stall_cnt_q;

  // Countdown runs regardless of stall; a fresh issue overrides expiry
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (pend_q[r]) begin
        if (cnt_q[r] <= LW'(1)) begin
          pend_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LW'(1);
        end
      end
    end
    if (issue_c) begin
      pend_d[bus.iss_addr_i] = 1'b1;
      cnt_d[bus.iss_addr_i]  = lat_eff_c;
    end
    if (bus.flush_i) begin
      pend_d = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
    end
    pend_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      pend_q      <= '0;
      stall_cnt_q <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed and randomized checks of bypass_scoreboard against a countdown
// reference model of register write latencies.
module tb_bypass_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NSRC = 8;
  localparam int unsigned LW   = 3;
  localparam int unsigned NREG = 32;

  logic clk;
  logic rsn;
  int   tests;
  int   fails;

  int          rem [NREG];
  logic [31:0] m_cnt;

  bypass_scoreboard_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NSRC(NSRC), .LW(LW)) bus ();

  bypass_scoreboard #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NSRC(NSRC), .LW(LW)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  // Youngest tap carrying register a
  function automatic bit m_hit(input int a, output logic [31:0] d);
    d = '0;
    if (a == 0) return 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (bus.src_wr_en_i[s] && (int'(bus.src_addr_i[s*AW +: AW]) == a)) begin
        d = bus.src_data_i[s*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit          raw;
    bit          waw;
    int          a;
    logic [31:0] d;
    raw = 1'b0;
    if (!rsn || !bus.iss_valid_i || bus.flush_i) return 1'b0;
    for (int p = 0; p < NRD; p++) begin
      a = int'(bus.rd_addr_i[p*AW +: AW]);
      if (bus.rd_en_i[p] && a != 0 && rem[a] > 0 && !m_hit(a, d)) raw = 1'b1;
    end
    a   = int'(bus.iss_addr_i);
    waw = bus.iss_wr_en_i && rem[a] > 0 && rem[a] > eff(int'(bus.iss_lat_i));
    return raw || waw;
  endfunction

  task automatic m_bypass(output logic [NRD-1:0] en, output logic [NRD*XLEN-1:0] dat);
    logic [31:0] d;
    int          a;
    en  = '0;
    dat = '0;
    for (int p = 0; p < NRD; p++) begin
      a = int'(bus.rd_addr_i[p*AW +: AW]);
      if (rsn && bus.rd_en_i[p] && m_hit(a, d)) begin
        en[p]               = 1'b1;
        dat[p*XLEN +: XLEN] = d;
      end
    end
  endtask

  task automatic m_update();
    bit st;
    st = m_stall();
    if (!rsn) begin
      for (int r = 0; r < NREG; r++) rem[r] = 0;
      m_cnt = '0;
    end else begin
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (bus.flush_i) begin
        for (int r = 0; r < NREG; r++) rem[r] = 0;
      end else begin
        for (int r = 0; r < NREG; r++) if (rem[r] > 0) rem[r] = rem[r] - 1;
        if (bus.iss_valid_i && bus.iss_wr_en_i && !st && bus.iss_addr_i != '0)
          rem[int'(bus.iss_addr_i)] = eff(int'(bus.iss_lat_i));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clr_in();
    bus.rd_addr_i   = '0;
    bus.rd_en_i     = '0;
    bus.iss_valid_i = 1'b0;
    bus.iss_wr_en_i = 1'b0;
    bus.iss_addr_i  = '0;
    bus.iss_lat_i   = '0;
    bus.flush_i     = 1'b0;
    bus.src_data_i  = '0;
    bus.src_addr_i  = '0;
    bus.src_wr_en_i = '0;
  endtask

  task automatic set_tap(input int s, input int a, input logic [31:0] d);
    bus.src_wr_en_i[s]              = 1'b1;
    bus.src_addr_i[s*AW +: AW]      = AW'(a);
    bus.src_data_i[s*XLEN +: XLEN]  = d;
  endtask

  task automatic rd(input int p, input int a);
    bus.rd_en_i[p]             = 1'b1;
    bus.rd_addr_i[p*AW +: AW]  = AW'(a);
  endtask

  task automatic iss(input bit v, input bit w, input int a, input int l);
    bus.iss_valid_i = v;
    bus.iss_wr_en_i = w;
    bus.iss_addr_i  = AW'(a);
    bus.iss_lat_i   = LW'(l);
  endtask

  initial begin
    logic [NRD-1:0]      e_en;
    logic [NRD*XLEN-1:0] e_dat;
    tests = 0;
    fails = 0;
    m_cnt = '0;
    for (int r = 0; r < NREG; r++) rem[r] = 0;

    // Reset holds outputs quiet despite live taps and requests
    clr_in();
    rsn = 1'b0;
    for (int s = 0; s < NSRC; s++) set_tap(s, 3, 32'h0000_0033 + 32'(s));
    rd(0, 3); rd(1, 3);
    iss(1, 1, 3, 2);
    #1;
    chk("rst_en", 64'(bus.bypass_en_o), 64'd0);
    chk("rst_data", 64'(bus.bypass_data_o), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_en", 64'(bus.bypass_en_o), 64'd0);
      chk("rst_stall", 64'(bus.stall_o), 64'd0);
      tick();
      chk("rst_scnt", 64'(bus.stall_cnt_o), 64'd0);
    end

    // Nothing may be pending after release
    rsn = 1'b1;
    clr_in();
    for (int r = 1; r < NREG; r += 2) begin
      clr_in();
      iss(1, 0, 0, 0);
      rd(0, r);
      if (r + 1 < NREG) rd(1, r + 1);
      settle();
      chk("post_rst_pend", 64'(bus.stall_o), 64'd0);
      tick();
    end

    // Priority: exe tap beats cache tap
    clr_in();
    set_tap(0, 5, 32'hAAAA_0000);
    set_tap(6, 5, 32'h0000_BBBB);
    rd(0, 5);
    settle();
    chk("prio_en", 64'(bus.bypass_en_o), 64'd1);
    chk("prio_data", 64'(bus.bypass_data_o[31:0]), 64'hAAAA_0000);
    bus.src_wr_en_i[0] = 1'b0;
    #1;
    chk("prio_cache", 64'(bus.bypass_data_o[31:0]), 64'h0000_BBBB);
    bus.rd_addr_i[4:0] = '0;
    #1;
    chk("prio_r0_en", 64'(bus.bypass_en_o), 64'd0);
    chk("prio_r0_data", 64'(bus.bypass_data_o), 64'd0);
    tick();

    // RAW countdown on r7, forwarded on the last pending cycle
    clr_in();
    iss(1, 1, 7, 6);
    settle();
    chk("raw_issue", 64'(bus.stall_o), 64'd0);
    tick();
    clr_in();
    iss(1, 0, 0, 0);
    rd(0, 7);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("raw_stall", 64'(bus.stall_o), 64'd1);
      tick();
    end
    settle();
    chk("raw_last_nofwd", 64'(bus.stall_o), 64'd1);
    set_tap(3, 7, 32'h1234_5678);
    #1;
    chk("raw_fwd_stall", 64'(bus.stall_o), 64'd0);
    chk("raw_fwd_en", 64'(bus.bypass_en_o), 64'd1);
    chk("raw_fwd_data", 64'(bus.bypass_data_o[31:0]), 64'h1234_5678);
    tick();
    clr_in();
    iss(1, 0, 0, 0);
    rd(0, 7);
    settle();
    chk("raw_cleared", 64'(bus.stall_o), 64'd0);
    chk("raw_scnt", 64'(bus.stall_cnt_o), 64'd5);
    tick();

    // WAW: shorter re-issue waits until the old write is at most 1 away
    clr_in();
    iss(1, 1, 4, 5);
    tick();
    iss(1, 1, 4, 1);
    for (int c = 5; c >= 1; c--) begin
      settle();
      chk("waw_stall", 64'(bus.stall_o), (c > 1) ? 64'd1 : 64'd0);
      tick();
    end
    iss(1, 0, 0, 0);
    rd(0, 4);
    settle();
    chk("waw_reissued", 64'(bus.stall_o), 64'd1);
    tick();
    settle();
    chk("waw_expired", 64'(bus.stall_o), 64'd0);
    tick();
    clr_in();
    iss(1, 1, 4, 5);
    tick();
    iss(1, 1, 4, 6);
    settle();
    chk("waw_longer", 64'(bus.stall_o), 64'd0);
    tick();
    iss(1, 1, 4, 5);
    settle();
    chk("waw_reload6", 64'(bus.stall_o), 64'd1);
    iss(1, 1, 4, 6);
    #1;
    chk("waw_reload6_eq", 64'(bus.stall_o), 64'd0);
    iss(0, 0, 0, 0);
    tick();

    // Flush clears pending r9 and suppresses the r10 issue
    clr_in();
    iss(1, 1, 9, 7);
    tick();
    iss(1, 1, 10, 3);
    rd(0, 9);
    bus.flush_i = 1'b1;
    settle();
    chk("flush_stall", 64'(bus.stall_o), 64'd0);
    tick();
    clr_in();
    iss(1, 0, 0, 0);
    rd(0, 9);
    settle();
    chk("flush_r9", 64'(bus.stall_o), 64'd0);
    bus.rd_addr_i[4:0] = 5'd10;
    #1;
    chk("flush_r10", 64'(bus.stall_o), 64'd0);
    tick();

    // Expiry and re-issue of r2 in the same cycle
    clr_in();
    iss(1, 1, 2, 2);
    tick();
    iss(0, 0, 0, 0);
    tick();
    iss(1, 1, 2, 4);
    settle();
    chk("simul_issue", 64'(bus.stall_o), 64'd0);
    tick();
    iss(1, 0, 0, 0);
    rd(0, 2);
    settle();
    chk("simul_pend", 64'(bus.stall_o), 64'd1);
    clr_in();
    iss(1, 1, 2, 3);
    #1;
    chk("simul_cnt4_gt3", 64'(bus.stall_o), 64'd1);
    iss(1, 1, 2, 4);
    #1;
    chk("simul_cnt4_eq4", 64'(bus.stall_o), 64'd0);
    iss(0, 0, 0, 0);
    tick();

    // Reset mid-operation drops tracking and the stall count
    clr_in();
    iss(1, 1, 12, 7);
    tick();
    rsn = 1'b0;
    iss(1, 0, 0, 0);
    rd(0, 12);
    set_tap(2, 12, 32'hDEAD_BEEF);
    settle();
    chk("midrst_en", 64'(bus.bypass_en_o), 64'd0);
    chk("midrst_data", 64'(bus.bypass_data_o), 64'd0);
    tick();
    rsn = 1'b1;
    clr_in();
    iss(1, 0, 0, 0);
    rd(0, 12);
    settle();
    chk("midrst_pend", 64'(bus.stall_o), 64'd0);
    chk("midrst_scnt", 64'(bus.stall_cnt_o), 64'd0);
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bus.rd_en_i     = NRD'($urandom_range(0, 3));
      for (int p = 0; p < NRD; p++) bus.rd_addr_i[p*AW +: AW] = AW'($urandom_range(0, 7));
      bus.iss_valid_i = ($urandom_range(0, 3) != 0);
      bus.iss_wr_en_i = ($urandom_range(0, 1) != 0);
      bus.iss_addr_i  = AW'($urandom_range(0, 7));
      bus.iss_lat_i   = LW'($urandom_range(0, 7));
      bus.flush_i     = ($urandom_range(0, 15) == 0);
      bus.src_wr_en_i = NSRC'($urandom & $urandom);
      for (int s = 0; s < NSRC; s++) begin
        bus.src_addr_i[s*AW +: AW]     = AW'($urandom_range(0, 7));
        bus.src_data_i[s*XLEN +: XLEN] = $urandom;
      end
      settle();
      m_bypass(e_en, e_dat);
      chk("rand_en", 64'(bus.bypass_en_o), 64'(e_en));
      chk("rand_data", 64'(bus.bypass_data_o), 64'(e_dat));
      chk("rand_stall", 64'(bus.stall_o), 64'(m_stall()));
      tick();
      chk("rand_scnt", 64'(bus.stall_cnt_o), 64'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
